z_symbol_decoder: RTL and testbench

//  Receive-side counterpart of the 2-bit symbol encoder, which emits Z1 = X1 XNOR X2 and Z2 = X1.

---
 rtl/z_symbol_decoder.sv | 133 +++++++++++++
 tb/tb_z_symbol_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/z_symbol_decoder.sv
// z_symbol_decoder: turns encoded (Z1,Z2) pairs back into 2-bit symbols and packs
// SYMS_PER_WORD of them into a word. Each word is held on a registered valid/ready
// output. A flush pulse emits a partially filled word, left-aligned to the MSB end.
module z_symbol_decoder #(
  parameter int SYMS_PER_WORD = 4,
  parameter int W             = 2 * SYMS_PER_WORD,
  parameter int CNT_W         = $clog2(SYMS_PER_WORD + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       z_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [0:0] {
    ACCUM      = 1'b0,
    FLUSH_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SYMS_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMS_PER_WORD - 1);

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             slot_free_s;
  logic             accept_s;
  logic [1:0]       sym_s;
  logic [W-1:0]     eff_acc_s;
  logic [CNT_W-1:0] eff_cnt_s;
  logic [CNT_W:0]   shamt_s;
  logic [W-1:0]     aligned_s;

  // The output slot can take a new word when empty or being drained this cycle.
  assign slot_free_s = ~out_valid_q | out_ready;
  // Only the cycle that completes a word needs the slot; earlier symbols just accumulate.
  assign in_ready    = ~reset & (state_q == ACCUM) & (slot_free_s | (cnt_q < LAST_CNT));
  assign accept_s    = in_valid & in_ready;
  // X[1] = Z2, X[0] = Z1 XNOR Z2.
  assign sym_s       = {z_in[0], ~(z_in[1] ^ z_in[0])};
  // Accumulator and count as they stand after any accept in this cycle.
  assign eff_acc_s   = accept_s ? {acc_q[W-3:0], sym_s} : acc_q;
  assign eff_cnt_s   = accept_s ? (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_q;
  // Left-align a partial word. A full word has a shift of zero.
  assign shamt_s     = {FULL_CNT - eff_cnt_s, 1'b0};
  assign aligned_s   = eff_acc_s << shamt_s;

  // Next-state logic: accumulate, load full or flushed words, and wait for the slot during a blocked flush.
  always_comb begin
    state_d     = state_q;
    acc_d       = eff_acc_s;
    cnt_d       = eff_cnt_s;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    case (state_q)
      ACCUM: begin
        if (eff_cnt_s == FULL_CNT) begin
          // in_ready guaranteed the slot is free for this load.
          out_valid_d = 1'b1;
          out_data_d  = aligned_s;
          out_count_d = FULL_CNT;
          acc_d       = '0;
          cnt_d       = '0;
        end else if (flush && (eff_cnt_s != '0)) begin
          if (slot_free_s) begin
            out_valid_d = 1'b1;
            out_data_d  = aligned_s;
            out_count_d = eff_cnt_s;
            acc_d       = '0;
            cnt_d       = '0;
          end else begin
            state_d = FLUSH_WAIT;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      FLUSH_WAIT: begin
        // No accepts happen here, so the effective values equal the held ones.
        if (slot_free_s) begin
          out_valid_d = 1'b1;
          out_data_d  = aligned_s;
          out_count_d = eff_cnt_s;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = ACCUM;
        end else begin
          state_d = FLUSH_WAIT;
        end
      end
      default: begin
        state_d = ACCUM;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset that discards any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_z_symbol_decoder.sv
// Testbench for z_symbol_decoder: directed vectors with hand-computed words, then a
// random phase checked against a queue of decoded symbols.
module tb_z_symbol_decoder;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   z_in;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   out_count;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;
  logic [1:0] sb_q[$];

  z_symbol_decoder #(.SYMS_PER_WORD(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z_in      (z_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one pair, waiting for in_ready for at most 20 cycles.
  task automatic send(input logic [1:0] z);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    z_in     = z;
    #1;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Reference decode table written out from the encoder truth table.
  function automatic logic [1:0] ref_dec(input logic [1:0] z);
    case (z)
      2'b10:   ref_dec = 2'b00;
      2'b00:   ref_dec = 2'b01;
      2'b01:   ref_dec = 2'b10;
      default: ref_dec = 2'b11;
    endcase
  endfunction

  // Random-phase monitor: pops delivered words and then records accepts.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) begin
        logic [W-1:0] expw;
        int cnt;
        expw = '0;
        cnt  = int'(out_count);
        check("rnd_count_range", {31'd0, (cnt >= 1 && cnt <= N)}, 32'd1);
        check("rnd_enough_syms", {31'd0, (sb_q.size() >= cnt)}, 32'd1);
        for (int i = 0; i < cnt && i < N; i++) begin
          if (sb_q.size() > 0) expw[W-1-2*i -: 2] = sb_q.pop_front();
        end
        check("rnd_data", {24'd0, out_data}, {24'd0, expw});
      end
      if (in_valid && in_ready) sb_q.push_back(ref_dec(z_in));
    end
  end

  initial begin
    logic [1:0] t1 [4];
    t1[0] = 2'b10; t1[1] = 2'b00; t1[2] = 2'b01; t1[3] = 2'b11;
    reset = 1'b1; in_valid = 1'b0; z_in = 2'b00; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_count", {29'd0, out_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // T1: decode/pack, single-cycle valid
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      z_in = t1[i];
      tick();
      if (i == 2) check("t1_not_early", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_data", {24'd0, out_data}, 32'h1B);
    check("t1_count", {29'd0, out_count}, 32'd4);
    tick();
    check("t1_one_cycle", {31'd0, out_valid}, 32'd0);

    // T2: backpressure, drain and reload without a bubble
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(t1[i]);
    check("t2_pending", {24'd0, out_data}, 32'h1B);
    in_valid = 1'b1;
    z_in     = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_accept_ok", {31'd0, in_ready}, 32'd1);
      tick();
    end
    check("t2_blocked", {31'd0, in_ready}, 32'd0);
    tick();
    check("t2_still_blocked", {31'd0, in_ready}, 32'd0);
    check("t2_stable_data", {24'd0, out_data}, 32'h1B);
    check("t2_stable_count", {29'd0, out_count}, 32'd4);
    out_ready = 1'b1;
    #1;
    check("t2_unblocked", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("t2_no_gap", {31'd0, out_valid}, 32'd1);
    check("t2_ff", {24'd0, out_data}, 32'hFF);
    tick();
    check("t2_drained", {31'd0, out_valid}, 32'd0);

    // T3: flush a partial word, then the next word starts at the MSB slot
    send(2'b11);
    send(2'b01);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_valid", {31'd0, out_valid}, 32'd1);
    check("t3_data", {24'd0, out_data}, 32'hE0);
    check("t3_count", {29'd0, out_count}, 32'd2);
    send(2'b01);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_next_msb", {24'd0, out_data}, 32'h80);
    check("t3_next_count", {29'd0, out_count}, 32'd1);
    tick();

    // T4: flush while the output is blocked
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2'b11);
    send(2'b00);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_wait_ready", {31'd0, in_ready}, 32'd0);
    check("t4_held_ff", {24'd0, out_data}, 32'hFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_wait_ready2", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    check("t4_wait_on_drain", {31'd0, in_ready}, 32'd0);
    tick();
    check("t4_partial_valid", {31'd0, out_valid}, 32'd1);
    check("t4_partial_data", {24'd0, out_data}, 32'h40);
    check("t4_partial_count", {29'd0, out_count}, 32'd1);
    check("t4_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    check("t4_drained", {31'd0, out_valid}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_empty_flush", {31'd0, out_valid}, 32'd0);

    // T5: reset mid-word discards partial data
    for (int i = 0; i < 3; i++) send(2'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) send(t1[i]);
    check("t5_clean_data", {24'd0, out_data}, 32'h1B);
    check("t5_clean_count", {29'd0, out_count}, 32'd4);
    check("t5_clean_valid", {31'd0, out_valid}, 32'd1);
    tick();

    // T6: random traffic against the symbol scoreboard
    sb_q.delete();
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      z_in      = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    mon_en = 1'b0;
    check("t6_all_delivered", sb_q.size(), 32'd0);
    check("t6_idle", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
